// File: rtl/message_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : message_scroller
//  Description : Shows a circular 4-character window of a 16-nibble message
//                on a multiplexed 4-digit common-anode 7-segment display.
//                The window advances on a timer or on a manual step edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module message_scroller #(
  parameter int SCROLL_DIV  = 25_000_000,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] message,
  input  logic        auto_scroll,
  input  logic        step,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  scroll_pos
);

  localparam int SCW = $clog2(SCROLL_DIV);
  localparam int RFW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SCW-1:0] SCROLL_LAST  = SCW'(SCROLL_DIV - 1);
  localparam logic [RFW-1:0] REFRESH_LAST = RFW'(REFRESH_DIV - 1);

  logic [SCW-1:0] r_scroll_cnt;
  logic [RFW-1:0] r_refresh_cnt;
  logic [3:0]     r_ptr;
  logic [1:0]     r_dsel;
  logic           r_sync1;
  logic           r_sync2;
  logic           r_step_prev;
  logic           w_step_rise;
  logic [3:0]     w_idx;
  logic [3:0]     w_char;
  logic [6:0]     w_seg;

  // The step level is asynchronous: two flops resolve metastability, the
  // third holds the previous synchronized level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      r_sync1     <= step;
      r_sync2     <= r_sync1;
      r_step_prev <= r_sync2;
    end
  end

  assign w_step_rise = r_sync2 & ~r_step_prev;

  // Window pointer: timer-driven in auto mode, step-edge-driven otherwise.
  // A step edge detected while auto mode is active is simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scroll_cnt <= '0;
      r_ptr        <= 4'd0;
    end else if (auto_scroll) begin
      if (r_scroll_cnt == SCROLL_LAST) begin
        r_scroll_cnt <= '0;
        r_ptr        <= r_ptr + 4'd1;
      end else begin
        r_scroll_cnt <= r_scroll_cnt + SCW'(1);
      end
    end else begin
      r_scroll_cnt <= '0;
      if (w_step_rise) begin
        r_ptr <= r_ptr + 4'd1;
      end
    end
  end

  // Digit multiplex timer: each digit stays selected for REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_dsel        <= 2'd0;
    end else if (r_refresh_cnt == REFRESH_LAST) begin
      r_refresh_cnt <= '0;
      r_dsel        <= r_dsel + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + RFW'(1);
    end
  end

  // Leftmost digit (an[3]) shows character ptr, so digit i shows ptr+3-i;
  // 4-bit arithmetic gives the mod-16 wrap for free.
  assign w_idx  = r_ptr + 4'd3 - {2'b00, r_dsel};
  assign w_char = message[{w_idx, 2'b00} +: 4];

  // Hex-to-7-segment decode, active-low {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_char)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Anode and segment outputs are registered together so a digit is never
  // lit with another digit's pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(4'b0001 << r_dsel);
      seg <= w_seg;
    end
  end

  assign dp         = 1'b1;
  assign scroll_pos = r_ptr;

endmodule
`default_nettype wire

// File: doc/message_scroller.md
# message_scroller

Display-side consumer of the 64-bit, 16-nibble message register: `message[4k+3:4k]` is character k. It shows a 4-character window of the message on a 4-digit, common-anode 7-segment display and time-multiplexes the digits. The window advances either automatically on a timer or on a manual step input, wrapping circularly over all 16 characters.

## Interface
- `SCROLL_DIV`, default 25_000_000: clk cycles per automatic scroll step (≥2).
- `REFRESH_DIV`, default 50_000: clk cycles each digit stays lit (≥1).
- `clk`  in  1: system clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `message`  in  64: character k on bits [4k+3:4k]; sampled combinationally every cycle.
- `auto_scroll`  in  1: 1 = timer-driven scrolling, 0 = manual stepping.
- `step`  in  1: debounced level from the upstream debouncer, asynchronous to clk; a rising edge advances the window when auto_scroll = 0.
- `an`  out  4: digit anodes, active-low; an[3] is the leftmost digit.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low; always 1 (off).
- `scroll_pos`  out  4: current window start index `ptr`.

## Operation
- **Window:** digit i (an[i]) shows character `(ptr + 3 − i) mod 16`, so the leftmost digit shows character ptr.
- **Pointer:** 4-bit `ptr`. Increments by 1 per advance event and wraps 15 → 0 (natural 4-bit overflow). Index arithmetic is mod 16.
- **Auto mode (auto_scroll = 1):**
  - Scroll counter counts 0..SCROLL_DIV−1.
  - At terminal count, ptr increments and the counter returns to 0.
  - Step edges are ignored.
- **Manual mode (auto_scroll = 0):**
  - Scroll counter is held at 0.
  - `step` passes through a 2-flop synchronizer, then a rising-edge detector.
  - Each detected edge produces exactly one increment; a held-high step gives no further increments.
- **Mode switch:**
  - 0→1: counting starts from 0, so the first auto step occurs SCROLL_DIV cycles later.
  - 1→0: the counter clears on the next edge.
  - A step edge whose detection cycle coincides with auto_scroll = 1 is discarded.
- **Refresh:**
  - Refresh counter counts 0..REFRESH_DIV−1.
  - At terminal count, digit select `dsel` advances 0→1→2→3→0.
  - REFRESH_DIV = 1 advances dsel every cycle.
- **Hex decode (active-low {g..a}):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Output stage:** each cycle, `an` ← ~(1 << dsel) and `seg` ← decode(char for dsel at current ptr). Both are registered together, so they never disagree.

## Timing
- **Reset (asynchronous, immediate):**
  - an = 1111, seg = 1111111, dp = 1, scroll_pos = 0.
  - ptr = 0, dsel = 0, both counters = 0, synchronizer and edge flops = 0.
- **First edge after reset release:** an = 1110, seg = decode(message char 3).
- **an/seg latency:** one cycle after dsel or ptr changes.
- **scroll_pos** is ptr directly, so it updates on the same edge as the increment.
- **Manual latency:** a step rising edge sampled at edge n increments ptr at edge n+2 (two synchronizer stages, edge detect, registered increment). The new ptr appears on an/seg at edge n+3.
- **Auto spacing:** exactly SCROLL_DIV cycles between increments.
- **Refresh:** each digit is lit for exactly REFRESH_DIV cycles. Full frame = 4·REFRESH_DIV cycles.
- **Independence:** a ptr increment and a dsel advance in the same cycle are independent. The next registered output uses the new values of both.
- **Message changes** are visible one cycle later on the currently lit digit. No internal copy of the message is kept.
- **Reset mid-scroll or mid-refresh** discards all state immediately. No partial advance completes.

## Test plan
1. **Reset and first frame.** Params SCROLL_DIV = 8, REFRESH_DIV = 2; message = 0xFEDCBA9876543210.
   - Hold reset → an = 1111, seg = 1111111, scroll_pos = 0.
   - Release → next edge an = 1110, seg = 0110000 ("3").
2. **Refresh rotation.** auto_scroll = 0, ptr = 0.
   - an sequence 1110, 1101, 1011, 0111, each held 2 cycles.
   - seg = decode 3, 2, 1, 0 respectively; then repeats.
3. **Auto scroll and wrap.** auto_scroll = 1.
   - scroll_pos increments every 8 cycles.
   - At scroll_pos = 14, digits 3..0 show E, F, 0, 1.
   - After 16 steps, scroll_pos = 0.
4. **Manual step.** auto_scroll = 0; three step pulses, each high 5 cycles, low 5 cycles.
   - scroll_pos = 3, each increment 2 edges after the sampled rise.
   - Holding step high 100 cycles → no further change.
5. **Asynchronous reset mid-operation.** At scroll_pos = 9, mid-refresh, assert reset between edges.
   - Immediately an = 1111, seg = 1111111, scroll_pos = 0.
6. **Mode switch and live message.**
   - Step edge with auto_scroll = 1 → no extra increment.
   - Switch 0→1 → first increment after exactly 8 cycles.
   - Change message to 0xAAAAAAAAAAAAAAAA → every digit shows seg = 0001000 within one cycle of being lit.
